// File: rtl/ctl_decode_stage.sv
// ID/EX control decode stage: decodes op/funct into the control bundle, holds it in a
// valid/ready register, sequences MULT/DIV occupancy of HI/LO and stalls HI/LO hazards.
module ctl_decode_stage #(
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 32,
  parameter int unsigned CNT_W      = 6,
  parameter bit          ILLEGAL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid_i,
  input  logic [5:0] instr_op_ctl_i,
  input  logic [5:0] instr_funct_ctl_i,
  input  logic       flush_i,
  input  logic       ex_ready_i,
  output logic       stall_o,
  output logic       ctl_valid_o,
  output logic       reg_src_ctl_o,
  output logic       reg_dst_ctl_o,
  output logic       jump_ctl_o,
  output logic       branch_ctl_o,
  output logic       mem_read_ctl_o,
  output logic       mem_to_reg_ctl_o,
  output logic       mem_wr_ctl_o,
  output logic       reg_wr_ctl_o,
  output logic       sign_ext_ctl_o,
  output logic [5:0] alu_op_ctl_o,
  output logic [2:0] alu_src_ctl_o,
  output logic       illegal_o,
  output logic       md_start_o,
  output logic [1:0] md_op_o,
  output logic       md_busy_o
);

  localparam logic [5:0] OpRtype = 6'h00, OpRegimm = 6'h01, OpJ    = 6'h02, OpJal  = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04, OpBne    = 6'h05, OpBlez = 6'h06, OpBgtz = 6'h07;
  localparam logic [5:0] OpAddi  = 6'h08, OpAddiu  = 6'h09, OpSlti = 6'h0A, OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C, OpOri    = 6'h0D, OpXori = 6'h0E, OpLui  = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20, OpLh     = 6'h21, OpLw   = 6'h23, OpLbu  = 6'h24;
  localparam logic [5:0] OpLhu   = 6'h25, OpSb     = 6'h28, OpSh   = 6'h29, OpSw   = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00, FnSrl  = 6'h02, FnSra   = 6'h03, FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06, FnSrav = 6'h07, FnJr    = 6'h08, FnJalr  = 6'h09;
  localparam logic [5:0] FnSys  = 6'h0C, FnMfhi = 6'h10, FnMthi  = 6'h11, FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo = 6'h13, FnMult = 6'h18, FnMultu = 6'h19, FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu = 6'h1B, FnAdd  = 6'h20, FnAddu  = 6'h21, FnSub   = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23, FnAnd  = 6'h24, FnOr    = 6'h25, FnXor   = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27, FnSlt  = 6'h2A, FnSltu  = 6'h2B;

  localparam logic [5:0] AluAdd = 6'b000000, AluSub = 6'b000001, AluSll  = 6'b000010;
  localparam logic [5:0] AluSrl = 6'b000100, AluSra = 6'b000110, AluOr   = 6'b001000;
  localparam logic [5:0] AluAnd = 6'b010000, AluNor = 6'b011000, AluXor  = 6'b100000;
  localparam logic [5:0] AluSlt = 6'b101001, AluSltu = 6'b110001;

  localparam logic [2:0] SrcRf = 3'b000, SrcImm = 3'b001, SrcShamt = 3'b010, SrcZero = 3'b100;

  typedef struct packed {
    logic       reg_src;
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_wr;
    logic       reg_wr;
    logic       sign_ext;
    logic [5:0] alu_op;
    logic [2:0] alu_src;
    logic       illegal;
    logic       is_md;
    logic [1:0] md_op;
  } ctl_t;

  ctl_t             w_dec, w_ctl_d, r_ctl;
  logic             w_hilo, w_bad, w_valid_d, r_valid;
  logic             w_accept, w_handoff, w_md_start;
  logic [CNT_W-1:0] w_cnt_d, r_cnt;

  // Combinational decode of the incoming op/funct into a control bundle.
  always_comb begin
    w_dec  = '0;
    w_hilo = 1'b0;
    w_bad  = 1'b0;
    unique case (instr_op_ctl_i)
      OpRtype: begin
        w_dec.reg_dst = 1'b1;
        w_dec.reg_wr  = 1'b1;
        unique case (instr_funct_ctl_i)
          FnSll:  begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSll; w_dec.alu_src = SrcShamt; end
          FnSrl:  begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSrl; w_dec.alu_src = SrcShamt; end
          FnSra:  begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSra; w_dec.alu_src = SrcShamt; end
          // Variable shifts take the amount from a register, so B stays on the rf port.
          FnSllv: begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSll; end
          FnSrlv: begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSrl; end
          FnSrav: begin w_dec.reg_src = 1'b1; w_dec.alu_op = AluSra; end
          FnJr, FnJalr: ;
          FnSys:  w_dec.reg_wr = 1'b0;
          FnMfhi, FnMthi, FnMflo, FnMtlo: w_hilo = 1'b1;
          FnMult, FnMultu, FnDiv, FnDivu: begin
            w_hilo       = 1'b1;
            w_dec.is_md  = 1'b1;
            w_dec.md_op  = instr_funct_ctl_i[1:0];
          end
          FnAdd, FnAddu: w_dec.alu_op = AluAdd;
          FnSub, FnSubu: w_dec.alu_op = AluSub;
          FnAnd:  w_dec.alu_op = AluAnd;
          FnOr:   w_dec.alu_op = AluOr;
          FnXor:  w_dec.alu_op = AluXor;
          FnNor:  w_dec.alu_op = AluNor;
          FnSlt:  w_dec.alu_op = AluSlt;
          FnSltu: w_dec.alu_op = AluSltu;
          default: w_bad = 1'b1;
        endcase
      end
      OpRegimm: begin
        w_dec.branch = 1'b1; w_dec.sign_ext = 1'b1; w_dec.alu_op = AluSub; w_dec.alu_src = SrcZero;
      end
      OpJ:   w_dec.jump = 1'b1;
      OpJal: begin w_dec.jump = 1'b1; w_dec.reg_wr = 1'b1; end
      OpBeq, OpBne: begin w_dec.branch = 1'b1; w_dec.sign_ext = 1'b1; w_dec.alu_op = AluSub; end
      OpBlez, OpBgtz: begin w_dec.branch = 1'b1; w_dec.sign_ext = 1'b1; w_dec.alu_src = SrcZero; end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        w_dec.alu_src  = SrcImm;
        w_dec.reg_wr   = 1'b1;
        w_dec.sign_ext = 1'b1;
        unique case (instr_op_ctl_i)
          OpSlti:  w_dec.alu_op = AluSlt;
          OpSltiu: w_dec.alu_op = AluSltu;
          OpAndi:  begin w_dec.alu_op = AluAnd; w_dec.sign_ext = 1'b0; end
          OpOri:   begin w_dec.alu_op = AluOr;  w_dec.sign_ext = 1'b0; end
          OpXori:  begin w_dec.alu_op = AluXor; w_dec.sign_ext = 1'b0; end
          default: w_dec.alu_op = AluAdd;
        endcase
      end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        w_dec.mem_read = 1'b1; w_dec.mem_to_reg = 1'b1; w_dec.reg_wr = 1'b1;
        w_dec.sign_ext = 1'b1; w_dec.alu_src = SrcImm;
      end
      OpSb, OpSh, OpSw: begin
        w_dec.mem_wr = 1'b1; w_dec.sign_ext = 1'b1; w_dec.alu_src = SrcImm;
      end
      default: w_bad = 1'b1;
    endcase
    // Undecodable: squash every side effect so EX treats it as a bubble plus a flag.
    if (w_bad) begin
      w_dec         = '0;
      w_dec.illegal = ILLEGAL_EN;
      w_hilo        = 1'b0;
    end
  end

  // Handshake: hold while EX is stalled, HI/LO consumers wait for the MULT/DIV unit.
  always_comb begin
    stall_o    = (r_valid & ~ex_ready_i) |
                 (instr_valid_i & w_hilo & ((r_cnt != '0) | (r_valid & r_ctl.is_md)));
    w_accept   = instr_valid_i & ~stall_o & ~flush_i;
    w_handoff  = r_valid & ex_ready_i;
    w_md_start = w_handoff & r_ctl.is_md & ~flush_i;
  end

  // Next state of the stage register; flush wins, and empty slots are zeroed.
  always_comb begin
    w_valid_d = r_valid;
    w_ctl_d   = r_ctl;
    if (flush_i) begin
      w_valid_d = 1'b0;
      w_ctl_d   = '0;
    end else if (w_accept) begin
      w_valid_d = 1'b1;
      w_ctl_d   = w_dec;
    end else if (w_handoff) begin
      w_valid_d = 1'b0;
      w_ctl_d   = '0;
    end
  end

  // Occupancy counter: loads on handoff of a MULT/DIV, otherwise runs down to zero.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_md_start) begin
      w_cnt_d = r_ctl.md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  // Stage register and sequencer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_ctl   <= w_ctl_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    ctl_valid_o      = r_valid;
    reg_src_ctl_o    = r_ctl.reg_src;
    reg_dst_ctl_o    = r_ctl.reg_dst;
    jump_ctl_o       = r_ctl.jump;
    branch_ctl_o     = r_ctl.branch;
    mem_read_ctl_o   = r_ctl.mem_read;
    mem_to_reg_ctl_o = r_ctl.mem_to_reg;
    mem_wr_ctl_o     = r_ctl.mem_wr;
    reg_wr_ctl_o     = r_ctl.reg_wr;
    sign_ext_ctl_o   = r_ctl.sign_ext;
    alu_op_ctl_o     = r_ctl.alu_op;
    alu_src_ctl_o    = r_ctl.alu_src;
    illegal_o        = r_ctl.illegal;
    md_start_o       = w_md_start;
    md_op_o          = w_md_start ? r_ctl.md_op : 2'b00;
    md_busy_o        = (r_cnt != '0);
  end

endmodule

// File: tb/tb_ctl_decode_stage.sv
// Bench for ctl_decode_stage: directed vector table, hand sequences for the multi-cycle
// cases, then randomized traffic against a rule-based reference model.
module tb_ctl_decode_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid_i, flush_i, ex_ready_i;
  logic [5:0] instr_op_ctl_i, instr_funct_ctl_i;

  logic       stall_o, ctl_valid_o, reg_src, reg_dst, jump, branch, mem_read, mem_to_reg;
  logic       mem_wr, reg_wr, sign_ext, illegal_o, md_start_o, md_busy_o;
  logic [5:0] alu_op;
  logic [2:0] alu_src;
  logic [1:0] md_op_o;

  logic       stall_n, valid_n, reg_src_n, reg_dst_n, jump_n, branch_n, mem_read_n;
  logic       mem_to_reg_n, mem_wr_n, reg_wr_n, sign_ext_n, illegal_n, md_start_n, md_busy_n;
  logic [5:0] alu_op_n;
  logic [2:0] alu_src_n;
  logic [1:0] md_op_n;

  logic [18:0] dut_bun, nil_bun;
  assign dut_bun = {reg_src, reg_dst, jump, branch, mem_read, mem_to_reg, mem_wr, reg_wr,
                    sign_ext, alu_op, alu_src, illegal_o};
  assign nil_bun = {reg_src_n, reg_dst_n, jump_n, branch_n, mem_read_n, mem_to_reg_n, mem_wr_n,
                    reg_wr_n, sign_ext_n, alu_op_n, alu_src_n, illegal_n};

  always #5 clk = ~clk;

  ctl_decode_stage #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .ILLEGAL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .instr_op_ctl_i(instr_op_ctl_i),
    .instr_funct_ctl_i(instr_funct_ctl_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .stall_o(stall_o), .ctl_valid_o(ctl_valid_o), .reg_src_ctl_o(reg_src),
    .reg_dst_ctl_o(reg_dst), .jump_ctl_o(jump), .branch_ctl_o(branch),
    .mem_read_ctl_o(mem_read), .mem_to_reg_ctl_o(mem_to_reg), .mem_wr_ctl_o(mem_wr),
    .reg_wr_ctl_o(reg_wr), .sign_ext_ctl_o(sign_ext), .alu_op_ctl_o(alu_op),
    .alu_src_ctl_o(alu_src), .illegal_o(illegal_o), .md_start_o(md_start_o),
    .md_op_o(md_op_o), .md_busy_o(md_busy_o));

  ctl_decode_stage #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .ILLEGAL_EN(1'b0)) dut_nil (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .instr_op_ctl_i(instr_op_ctl_i),
    .instr_funct_ctl_i(instr_funct_ctl_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .stall_o(stall_n), .ctl_valid_o(valid_n), .reg_src_ctl_o(reg_src_n),
    .reg_dst_ctl_o(reg_dst_n), .jump_ctl_o(jump_n), .branch_ctl_o(branch_n),
    .mem_read_ctl_o(mem_read_n), .mem_to_reg_ctl_o(mem_to_reg_n), .mem_wr_ctl_o(mem_wr_n),
    .reg_wr_ctl_o(reg_wr_n), .sign_ext_ctl_o(sign_ext_n), .alu_op_ctl_o(alu_op_n),
    .alu_src_ctl_o(alu_src_n), .illegal_o(illegal_n), .md_start_o(md_start_n),
    .md_op_o(md_op_n), .md_busy_o(md_busy_n));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk(input bit rs, rd, j, br, mr, m2r, mw, rw, se,
                                     input logic [5:0] ao, input logic [2:0] as, input bit il);
    return {rs, rd, j, br, mr, m2r, mw, rw, se, ao, as, il};
  endfunction

  // Reference decode derived from instruction classes rather than a per-opcode table.
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output logic [18:0] bun, output bit hilo,
                                     output bit md, output logic [1:0] mdop);
    bit is_r, legal_fn, itype, load, store, br, legal, rs, se, rw;
    logic [5:0] ao;
    logic [2:0] as;
    is_r     = (op == 6'h00);
    legal_fn = fn inside {[6'h00:6'h00], [6'h02:6'h04], [6'h06:6'h09], 6'h0C, [6'h10:6'h13],
                          [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B};
    itype    = op inside {[6'h08:6'h0F]};
    load     = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    store    = op inside {6'h28, 6'h29, 6'h2B};
    br       = op inside {[6'h04:6'h07], 6'h01};
    legal    = (is_r && legal_fn) || itype || load || store || br || op inside {6'h02, 6'h03};
    rs = is_r && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
    rw = (is_r && fn != 6'h0C) || itype || load || op == 6'h03;
    se = (itype && !(op inside {6'h0C, 6'h0D, 6'h0E})) || load || store || br;
    ao = 6'b000000;
    if (itype) begin
      case (op)
        6'h0A: ao = 6'b101001;
        6'h0B: ao = 6'b110001;
        6'h0C: ao = 6'b010000;
        6'h0D: ao = 6'b001000;
        6'h0E: ao = 6'b100000;
        default: ao = 6'b000000;
      endcase
    end else if (is_r) begin
      case (fn)
        6'h00, 6'h04: ao = 6'b000010;
        6'h02, 6'h06: ao = 6'b000100;
        6'h03, 6'h07: ao = 6'b000110;
        6'h22, 6'h23: ao = 6'b000001;
        6'h24: ao = 6'b010000;
        6'h25: ao = 6'b001000;
        6'h26: ao = 6'b100000;
        6'h27: ao = 6'b011000;
        6'h2A: ao = 6'b101001;
        6'h2B: ao = 6'b110001;
        default: ao = 6'b000000;
      endcase
    end else if (br && op inside {6'h01, 6'h04, 6'h05}) begin
      ao = 6'b000001;
    end
    as = 3'b000;
    if (itype || load || store) as = 3'b001;
    else if (br && op inside {6'h01, 6'h06, 6'h07}) as = 3'b100;
    else if (is_r && fn inside {6'h00, 6'h02, 6'h03}) as = 3'b010;
    bun  = mk(rs, is_r, op inside {6'h02, 6'h03}, br, load, load, store, rw, se, ao, as, 1'b0);
    hilo = is_r && (fn inside {[6'h10:6'h13], [6'h18:6'h1B]});
    md   = is_r && (fn inside {[6'h18:6'h1B]});
    mdop = fn[1:0];
    if (!legal) begin
      bun  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 3'b000, 1'b1);
      hilo = 1'b0;
      md   = 1'b0;
    end
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
    instr_valid_i     = v;
    instr_op_ctl_i    = op;
    instr_funct_ctl_i = fn;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [18:0] exp;
  } vec_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
  } ins_t;

  vec_t vecs[$];
  ins_t pool[16] = '{'{6'h00, 6'h18}, '{6'h00, 6'h19}, '{6'h00, 6'h1A}, '{6'h00, 6'h1B},
                     '{6'h00, 6'h10}, '{6'h00, 6'h12}, '{6'h00, 6'h11}, '{6'h00, 6'h13},
                     '{6'h00, 6'h20}, '{6'h23, 6'h00}, '{6'h2B, 6'h00}, '{6'h04, 6'h00},
                     '{6'h0D, 6'h00}, '{6'h02, 6'h00}, '{6'h00, 6'h3F}, '{6'h3F, 6'h00}};

  logic [18:0] m_bun, d_bun;
  logic        m_valid, m_md, e_stall, e_start;
  logic [1:0]  m_mdop, d_mdop;
  bit          d_hilo, d_md;
  int          m_cnt;
  ins_t        pick;

  initial begin
    reset = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
    drive(1'b0, 6'h00, 6'h00);

    vecs.push_back('{6'h00, 6'h20, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 3'b000, 0)}); // ADD
    vecs.push_back('{6'h0D, 6'h00, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b001000, 3'b001, 0)}); // ORI
    vecs.push_back('{6'h23, 6'h00, mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 6'b000000, 3'b001, 0)}); // LW
    vecs.push_back('{6'h2B, 6'h00, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b000000, 3'b001, 0)}); // SW
    vecs.push_back('{6'h04, 6'h00, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 6'b000001, 3'b000, 0)}); // BEQ
    vecs.push_back('{6'h06, 6'h00, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 6'b000000, 3'b100, 0)}); // BLEZ
    vecs.push_back('{6'h01, 6'h00, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 6'b000001, 3'b100, 0)}); // REGIMM
    vecs.push_back('{6'h02, 6'h00, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 3'b000, 0)}); // J
    vecs.push_back('{6'h03, 6'h00, mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 6'b000000, 3'b000, 0)}); // JAL
    vecs.push_back('{6'h00, 6'h00, mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 6'b000010, 3'b010, 0)}); // SLL
    vecs.push_back('{6'h00, 6'h07, mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 6'b000110, 3'b000, 0)}); // SRAV
    vecs.push_back('{6'h00, 6'h0C, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 3'b000, 0)}); // SYSCALL
    vecs.push_back('{6'h0C, 6'h00, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b010000, 3'b001, 0)}); // ANDI
    vecs.push_back('{6'h0B, 6'h00, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b110001, 3'b001, 0)}); // SLTIU
    vecs.push_back('{6'h00, 6'h27, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 6'b011000, 3'b000, 0)}); // NOR
    vecs.push_back('{6'h3F, 6'h00, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 3'b000, 1)}); // bad op
    vecs.push_back('{6'h00, 6'h3F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 3'b000, 1)}); // bad fn

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_valid", ctl_valid_o, 0);
    check("reset_bundle", dut_bun, 0);
    check("reset_busy", md_busy_o, 0);
    check("reset_start", md_start_o, 0);
    check("reset_stall", stall_o, 0);
    reset = 1'b0;

    // Directed table, back-to-back issue
    @(negedge clk);
    drive(1'b1, vecs[0].op, vecs[0].fn);
    #1 check("tbl_stall0", stall_o, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check($sformatf("tbl_valid[%0d]", i), ctl_valid_o, 1);
      check($sformatf("tbl_bundle[%0d]", i), dut_bun, vecs[i].exp);
      check($sformatf("tbl_nil_illegal[%0d]", i), illegal_n, 0);
      if (i + 1 < vecs.size()) drive(1'b1, vecs[i+1].op, vecs[i+1].fn);
      else drive(1'b0, 6'h00, 6'h00);
      #1 check($sformatf("tbl_stall[%0d]", i), stall_o, 0);
    end
    @(negedge clk);
    check("tbl_drain_valid", ctl_valid_o, 0);
    check("tbl_drain_bundle", dut_bun, 0);

    // MULT then MFLO with an unrelated ADD slipped in while busy
    drive(1'b1, 6'h00, 6'h18);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h12);
    #1;
    check("mult_start", md_start_o, 1);
    check("mult_op", md_op_o, 2'b00);
    check("mflo_stall_n", stall_o, 1);
    @(negedge clk);
    check("mult_busy_n1", md_busy_o, 1);
    drive(1'b1, 6'h00, 6'h20);
    #1 check("add_not_stalled", stall_o, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("mult_busy_n%0d", k), md_busy_o, 1);
      drive(1'b1, 6'h00, 6'h12);
      #1 check($sformatf("mflo_stall_n%0d", k), stall_o, 1);
    end
    @(negedge clk);
    check("mult_busy_n5", md_busy_o, 0);
    #1 check("mflo_accept_n5", stall_o, 0);
    @(negedge clk);
    check("mflo_valid", ctl_valid_o, 1);
    check("mflo_bundle", dut_bun, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 6'h00, 3'b000, 0));
    drive(1'b0, 6'h00, 6'h00);
    @(negedge clk);

    // SW held while EX is not ready, then released without duplication
    drive(1'b1, 6'h2B, 6'h00);
    @(negedge clk);
    ex_ready_i = 1'b0;
    drive(1'b1, 6'h00, 6'h20);
    #1 check("hold_stall0", stall_o, 1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", k), ctl_valid_o, 1);
      check($sformatf("hold_bundle%0d", k), dut_bun,
            mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 6'h00, 3'b001, 0));
      #1 check($sformatf("hold_stall%0d", k), stall_o, 1);
    end
    @(negedge clk);
    ex_ready_i = 1'b1;
    #1 check("release_stall", stall_o, 0);
    @(negedge clk);
    check("release_next", dut_bun, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 6'h00, 3'b000, 0));
    drive(1'b0, 6'h00, 6'h00);
    @(negedge clk);
    check("release_drain", ctl_valid_o, 0);

    // DIVU flushed at handoff never starts
    drive(1'b1, 6'h00, 6'h1B);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00);
    flush_i = 1'b1;
    #1 check("flush_no_start", md_start_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_valid", ctl_valid_o, 0);
    check("flush_busy", md_busy_o, 0);

    // Reset during a running DIV
    drive(1'b1, 6'h00, 6'h1A);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h20);
    #1;
    check("div_start", md_start_o, 1);
    check("div_op", md_op_o, 2'b10);
    @(negedge clk);
    check("div_busy", md_busy_o, 1);
    check("div_next_valid", ctl_valid_o, 1);
    drive(1'b0, 6'h00, 6'h00);
    reset = 1'b1;
    #1;
    check("rst_busy", md_busy_o, 0);
    check("rst_valid", ctl_valid_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the reference model
    m_valid = 1'b0; m_bun = '0; m_md = 1'b0; m_mdop = 2'b00; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd_valid", ctl_valid_o, m_valid);
      check("rnd_bundle", dut_bun, m_bun);
      check("rnd_busy", md_busy_o, m_cnt != 0);
      if ($urandom_range(0, 9) < 7) pick = pool[$urandom_range(0, 15)];
      else pick = ins_t'($urandom_range(0, 4095));
      drive($urandom_range(0, 3) != 0, pick.op, pick.fn);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 11) == 0);
      #1;
      ref_decode(instr_op_ctl_i, instr_funct_ctl_i, d_bun, d_hilo, d_md, d_mdop);
      e_stall = (m_valid && !ex_ready_i) ||
                (instr_valid_i && d_hilo && (m_cnt != 0 || (m_valid && m_md)));
      e_start = m_valid && ex_ready_i && !flush_i && m_md;
      check("rnd_stall", stall_o, e_stall);
      check("rnd_start", md_start_o, e_start);
      check("rnd_mdop", md_op_o, e_start ? m_mdop : 2'b00);
      check("rnd_nil", {valid_n, nil_bun, md_busy_n, stall_n, md_start_n, md_op_n},
            {m_valid, m_bun & ~19'h1, m_cnt != 0, e_stall, e_start, e_start ? m_mdop : 2'b00});
      if (e_start) m_cnt = m_mdop[1] ? 32 : 4;
      else if (m_cnt > 0) m_cnt--;
      if (flush_i) begin
        m_valid = 1'b0; m_bun = '0; m_md = 1'b0; m_mdop = 2'b00;
      end else if (instr_valid_i && !e_stall) begin
        m_valid = 1'b1; m_bun = d_bun; m_md = d_md; m_mdop = d_md ? d_mdop : 2'b00;
      end else if (m_valid && ex_ready_i) begin
        m_valid = 1'b0; m_bun = '0; m_md = 1'b0; m_mdop = 2'b00;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
